// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the ID/EX stage logic and the hazard sequencer.
// The pipeline side is the master; the sequencer is the slave.
interface pipeline_hazard_ctrl_if #(
   parameter int REG_NUM_WIDTH = 4,
   parameter int FWD_WIDTH     = 2
);
   logic [REG_NUM_WIDTH-1:0] rn_1;
   logic [REG_NUM_WIDTH-1:0] rn_2;
   logic                     use_rn1;
   logic                     use_rn2;
   logic                     md_start;
   logic [REG_NUM_WIDTH-1:0] rd_ex;
   logic                     ex_write;
   logic                     ex_is_load;
   logic [REG_NUM_WIDTH-1:0] rd_mem;
   logic                     mem_write;
   logic                     branch_taken;

   logic                     stall_if;
   logic                     stall_id;
   logic                     bubble_ex;
   logic                     flush_id;
   logic [FWD_WIDTH-1:0]     fwd_1;
   logic [FWD_WIDTH-1:0]     fwd_2;
   logic                     md_busy;
   logic                     md_done;

   modport master (
      output rn_1, rn_2, use_rn1, use_rn2, md_start, rd_ex, ex_write, ex_is_load,
             rd_mem, mem_write, branch_taken,
      input  stall_if, stall_id, bubble_ex, flush_id, fwd_1, fwd_2, md_busy, md_done
   );

   modport slave (
      input  rn_1, rn_2, use_rn1, use_rn2, md_start, rd_ex, ex_write, ex_is_load,
             rd_mem, mem_write, branch_taken,
      output stall_if, stall_id, bubble_ex, flush_id, fwd_1, fwd_2, md_busy, md_done
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall sequencer for the four-stage core: operand forwarding selects,
// load-use stalls, multiply/divide EX occupancy and taken-branch flushes.
module pipeline_hazard_ctrl #(
   parameter int REG_NUM_WIDTH = 4,
   parameter int FWD_WIDTH     = 2,
   parameter int MD_LATENCY    = 4
) (
   input logic                   clk,
   input logic                   rst_n,
   pipeline_hazard_ctrl_if.slave hz
);
   localparam int CNT_W = $clog2(MD_LATENCY);

   localparam logic [0:0] RUN     = 1'b0;
   localparam logic [0:0] MD_BUSY = 1'b1;

   localparam logic [FWD_WIDTH-1:0] FWD_RF  = FWD_WIDTH'(0);
   localparam logic [FWD_WIDTH-1:0] FWD_EX  = FWD_WIDTH'(1);
   localparam logic [FWD_WIDTH-1:0] FWD_MEM = FWD_WIDTH'(2);

   logic [0:0]       state;
   logic [0:0]       state_nxt;
   logic [CNT_W-1:0] md_cnt;
   logic [CNT_W-1:0] md_cnt_nxt;
   logic             lu;

   // A matching load in EX has no result yet, so only MEM may supply it.
   function automatic logic [FWD_WIDTH-1:0] fwd_sel(
      input logic                     use_rn,
      input logic [REG_NUM_WIDTH-1:0] rn,
      input logic                     ex_write,
      input logic                     ex_is_load,
      input logic [REG_NUM_WIDTH-1:0] rd_ex,
      input logic                     mem_write,
      input logic [REG_NUM_WIDTH-1:0] rd_mem
   );
      if (use_rn && ex_write && !ex_is_load && (rd_ex == rn)) return FWD_EX;
      if (use_rn && mem_write && (rd_mem == rn))              return FWD_MEM;
      return FWD_RF;
   endfunction

   assign lu = hz.ex_write && hz.ex_is_load &&
               ((hz.use_rn1 && (hz.rd_ex == hz.rn_1)) ||
                (hz.use_rn2 && (hz.rd_ex == hz.rn_2)));

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_nxt    = state;
      md_cnt_nxt   = md_cnt;
      hz.stall_if  = 1'b0;
      hz.stall_id  = 1'b0;
      hz.bubble_ex = 1'b0;
      hz.flush_id  = 1'b0;
      hz.fwd_1     = FWD_RF;
      hz.fwd_2     = FWD_RF;
      hz.md_busy   = 1'b0;
      hz.md_done   = 1'b0;

      if (rst_n) begin
         hz.fwd_1 = fwd_sel(hz.use_rn1, hz.rn_1, hz.ex_write, hz.ex_is_load,
                            hz.rd_ex, hz.mem_write, hz.rd_mem);
         hz.fwd_2 = fwd_sel(hz.use_rn2, hz.rn_2, hz.ex_write, hz.ex_is_load,
                            hz.rd_ex, hz.mem_write, hz.rd_mem);

         case (state)
            RUN: begin
               if (hz.branch_taken) begin
                  hz.flush_id  = 1'b1;
                  hz.bubble_ex = 1'b1;
               end else if (lu) begin
                  hz.stall_if  = 1'b1;
                  hz.stall_id  = 1'b1;
                  hz.bubble_ex = 1'b1;
               end else if (hz.md_start) begin
                  // Issue cycle counts toward occupancy, leaving MD_LATENCY-1 busy cycles.
                  state_nxt  = MD_BUSY;
                  md_cnt_nxt = CNT_W'(MD_LATENCY - 2);
               end
            end
            MD_BUSY: begin
               hz.md_busy   = 1'b1;
               hz.stall_if  = 1'b1;
               hz.stall_id  = 1'b1;
               hz.bubble_ex = 1'b1;
               md_cnt_nxt   = md_cnt - CNT_W'(1);
               if (md_cnt == '0) begin
                  hz.md_done = 1'b1;
                  state_nxt  = RUN;
                  md_cnt_nxt = '0;
               end
            end
            default: state_nxt = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      if (!rst_n) begin
         state  <= RUN;
         md_cnt <= '0;
      end else begin
         state  <= state_nxt;
         md_cnt <= md_cnt_nxt;
      end
   end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table, hand-written multi-cycle
// sequences and randomized traffic compared against a cycle-count reference model.
module tb_pipeline_hazard_ctrl;
   localparam int RW  = 4;
   localparam int FW  = 2;
   localparam int LAT = 4;

   typedef struct packed {
      logic [RW-1:0] rn_1;
      logic [RW-1:0] rn_2;
      logic          use_rn1;
      logic          use_rn2;
      logic          md_start;
      logic [RW-1:0] rd_ex;
      logic          ex_write;
      logic          ex_is_load;
      logic [RW-1:0] rd_mem;
      logic          mem_write;
      logic          branch_taken;
   } in_t;

   typedef struct packed {
      logic          stall_if;
      logic          stall_id;
      logic          bubble_ex;
      logic          flush_id;
      logic [FW-1:0] fwd_1;
      logic [FW-1:0] fwd_2;
      logic          md_busy;
      logic          md_done;
   } out_t;

   typedef struct {
      string name;
      in_t   in;
      out_t  exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;
   int   md_left = 0;   // reference model: EX busy cycles still owed to an MD op

   always #5 clk = ~clk;

   pipeline_hazard_ctrl_if #(.REG_NUM_WIDTH(RW), .FWD_WIDTH(FW)) hz ();

   pipeline_hazard_ctrl #(.REG_NUM_WIDTH(RW), .FWD_WIDTH(FW), .MD_LATENCY(LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hz.slave)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic in_t mk_in(input logic [RW-1:0] rn1, input logic [RW-1:0] rn2,
                                 input logic u1, input logic u2, input logic md,
                                 input logic [RW-1:0] rdex, input logic exw, input logic exl,
                                 input logic [RW-1:0] rdmem, input logic memw, input logic br);
      in_t r;
      r = {rn1, rn2, u1, u2, md, rdex, exw, exl, rdmem, memw, br};
      return r;
   endfunction

   function automatic out_t mk_out(input logic sif, input logic sid, input logic bx,
                                   input logic fl, input logic [FW-1:0] f1,
                                   input logic [FW-1:0] f2, input logic busy, input logic done);
      out_t r;
      r = {sif, sid, bx, fl, f1, f2, busy, done};
      return r;
   endfunction

   // Reference model: outputs from the spec rules and the number of owed busy cycles.
   function automatic out_t model_out(input in_t i, input logic rst, input int left);
      out_t o;
      logic lu;
      o = '0;
      if (!rst) return o;
      if (i.use_rn1 && i.ex_write && !i.ex_is_load && i.rd_ex == i.rn_1)  o.fwd_1 = 2'd1;
      else if (i.use_rn1 && i.mem_write && i.rd_mem == i.rn_1)            o.fwd_1 = 2'd2;
      if (i.use_rn2 && i.ex_write && !i.ex_is_load && i.rd_ex == i.rn_2)  o.fwd_2 = 2'd1;
      else if (i.use_rn2 && i.mem_write && i.rd_mem == i.rn_2)            o.fwd_2 = 2'd2;
      lu = i.ex_write && i.ex_is_load &&
           ((i.use_rn1 && i.rd_ex == i.rn_1) || (i.use_rn2 && i.rd_ex == i.rn_2));
      if (left > 0) begin
         o.md_busy = 1'b1; o.stall_if = 1'b1; o.stall_id = 1'b1; o.bubble_ex = 1'b1;
         o.md_done = (left == 1);
      end else if (i.branch_taken) begin
         o.flush_id = 1'b1; o.bubble_ex = 1'b1;
      end else if (lu) begin
         o.stall_if = 1'b1; o.stall_id = 1'b1; o.bubble_ex = 1'b1;
      end
      return o;
   endfunction

   task automatic model_step(input in_t i, input logic rst);
      logic lu;
      lu = i.ex_write && i.ex_is_load &&
           ((i.use_rn1 && i.rd_ex == i.rn_1) || (i.use_rn2 && i.rd_ex == i.rn_2));
      if (!rst)                                      md_left = 0;
      else if (md_left > 0)                          md_left--;
      else if (!i.branch_taken && !lu && i.md_start) md_left = LAT - 1;
   endtask

   // One clock: drive just after posedge, compare at negedge, advance the model at posedge.
   task automatic run_cycle(input in_t i, input logic rst, input logic has_exp,
                            input out_t exp, input string name, output out_t act);
      out_t m;
      rst_n           = rst;
      hz.rn_1         = i.rn_1;
      hz.rn_2         = i.rn_2;
      hz.use_rn1      = i.use_rn1;
      hz.use_rn2      = i.use_rn2;
      hz.md_start     = i.md_start;
      hz.rd_ex        = i.rd_ex;
      hz.ex_write     = i.ex_write;
      hz.ex_is_load   = i.ex_is_load;
      hz.rd_mem       = i.rd_mem;
      hz.mem_write    = i.mem_write;
      hz.branch_taken = i.branch_taken;
      @(negedge clk);
      act = {hz.stall_if, hz.stall_id, hz.bubble_ex, hz.flush_id,
             hz.fwd_1, hz.fwd_2, hz.md_busy, hz.md_done};
      m = model_out(i, rst, md_left);
      check({name, "/model"}, 32'(act), 32'(m));
      if (has_exp) check(name, 32'(act), 32'(exp));
      @(posedge clk);
      model_step(i, rst);
      #1;
   endtask

   vec_t vecs[12];
   in_t  idle;
   in_t  hot;
   out_t act;
   out_t zero_o;
   out_t busy_o;
   int   busy_cnt;
   int   done_cnt;

   initial begin
      idle   = '0;
      zero_o = '0;
      busy_o = mk_out(1, 1, 1, 0, 2'b00, 2'b00, 1, 0);
      hot    = mk_in(4'd3, 4'd3, 1, 1, 1, 4'd3, 1, 0, 4'd3, 1, 1);

      //             name          rn1 rn2 u1 u2 md rdex exw exl rdmem mw br     sif sid bx fl f1     f2    busy done
      vecs[0]  = '{"fwd_ex",      mk_in(3, 0, 1, 0, 0, 3, 1, 0, 3, 1, 0), mk_out(0, 0, 0, 0, 2'b01, 2'b00, 0, 0)};
      vecs[1]  = '{"fwd_mem",     mk_in(3, 0, 1, 0, 0, 4, 1, 0, 3, 1, 0), mk_out(0, 0, 0, 0, 2'b10, 2'b00, 0, 0)};
      vecs[2]  = '{"lu_rn2",      mk_in(0, 5, 0, 1, 0, 5, 1, 1, 0, 0, 0), mk_out(1, 1, 1, 0, 2'b00, 2'b00, 0, 0)};
      vecs[3]  = '{"after_lu",    mk_in(0, 5, 0, 1, 0, 9, 1, 0, 5, 1, 0), mk_out(0, 0, 0, 0, 2'b00, 2'b10, 0, 0)};
      vecs[4]  = '{"lu_mem_fwd",  mk_in(0, 5, 0, 1, 0, 5, 1, 1, 5, 1, 0), mk_out(1, 1, 1, 0, 2'b00, 2'b10, 0, 0)};
      vecs[5]  = '{"no_use_load", mk_in(6, 1, 0, 0, 0, 6, 1, 1, 0, 0, 0), mk_out(0, 0, 0, 0, 2'b00, 2'b00, 0, 0)};
      vecs[6]  = '{"branch_all",  mk_in(7, 0, 1, 0, 1, 7, 1, 1, 0, 0, 1), mk_out(0, 0, 1, 1, 2'b00, 2'b00, 0, 0)};
      vecs[7]  = '{"stay_run",    mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mk_out(0, 0, 0, 0, 2'b00, 2'b00, 0, 0)};
      vecs[8]  = '{"r0_fwd",      mk_in(0, 0, 1, 1, 0, 0, 1, 0, 0, 1, 0), mk_out(0, 0, 0, 0, 2'b01, 2'b01, 0, 0)};
      vecs[9]  = '{"ex_nowrite",  mk_in(1, 2, 0, 1, 0, 2, 0, 0, 2, 1, 0), mk_out(0, 0, 0, 0, 2'b00, 2'b10, 0, 0)};
      vecs[10] = '{"lu_md",       mk_in(8, 0, 1, 0, 1, 8, 1, 1, 8, 1, 0), mk_out(1, 1, 1, 0, 2'b10, 2'b00, 0, 0)};
      vecs[11] = '{"md_ignored",  mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mk_out(0, 0, 0, 0, 2'b00, 2'b00, 0, 0)};

      // Reset: outputs forced low even with every hazard input active.
      @(posedge clk);
      #1;
      run_cycle(hot, 1'b0, 1'b1, zero_o, "reset_hold", act);
      run_cycle(hot, 1'b0, 1'b1, zero_o, "reset_hold2", act);

      foreach (vecs[k]) run_cycle(vecs[k].in, 1'b1, 1'b1, vecs[k].exp, vecs[k].name, act);

      // Multiply/divide occupancy; a stray branch_taken while busy must be ignored.
      run_cycle(mk_in(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 1'b1, 1'b1, zero_o, "md_issue", act);
      busy_cnt = 0;
      done_cnt = 0;
      for (int k = 1; k < LAT; k++) begin
         out_t e;
         e = busy_o;
         e.md_done = (k == LAT - 1);
         run_cycle(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, k == 1), 1'b1, 1'b1, e, "md_busy_cyc", act);
         busy_cnt += int'(act.md_busy);
         done_cnt += int'(act.md_done);
      end
      run_cycle(idle, 1'b1, 1'b1, zero_o, "md_release", act);
      check("md_busy_cycles", 32'(busy_cnt), 32'd3);
      check("md_done_pulses", 32'(done_cnt), 32'd1);

      // Reset during the 2nd busy cycle: outputs drop at once, RUN after the edge, no md_done.
      run_cycle(mk_in(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 1'b1, 1'b1, zero_o, "rmd_issue", act);
      run_cycle(idle, 1'b1, 1'b1, busy_o, "rmd_busy1", act);
      run_cycle(hot, 1'b0, 1'b1, zero_o, "rmd_reset", act);
      run_cycle(idle, 1'b1, 1'b1, zero_o, "rmd_after", act);
      run_cycle(idle, 1'b1, 1'b1, zero_o, "rmd_after2", act);

      // Randomized traffic over a narrow register range so matches are frequent.
      for (int n = 0; n < 2000; n++) begin
         in_t  r;
         logic rst;
         r = mk_in(RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3) == 0, RW'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   RW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 7) == 0);
         rst = ($urandom_range(0, 63) != 0);
         run_cycle(r, rst, 1'b0, zero_o, "random", act);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Pipeline hazard and stall sequencer for the four-stage core (IF, ID, EX, MEM/WB). Each cycle it compares ID-stage source operands against the EX and MEM destinations to produce operand-forwarding selects. It also sequences load-use stalls, multi-cycle multiply/divide occupancy of the EX unit, and taken-branch flushes. It sits beside the ID/EX pipeline register and drives the IF/ID enables, the EX bubble mux and the ID operand muxes.

## Interface
- REG_NUM_WIDTH, 4, register-number width
- FWD_WIDTH, 2, forwarding-select width
- MD_LATENCY, 4, EX cycles occupied by a multiply/divide (legal range 2..15)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- rn_1, rn_2  in  REG_NUM_WIDTH  ID-stage source register numbers
- use_rn1, use_rn2  in  1  ID instruction actually reads rn_1 / rn_2
- md_start  in  1  ID instruction is a multiply/divide
- rd_ex  in  REG_NUM_WIDTH  EX-stage destination
- ex_write  in  1  EX instruction writes rd_ex
- ex_is_load  in  1  EX instruction is a load
- rd_mem  in  REG_NUM_WIDTH  MEM-stage destination
- mem_write  in  1  MEM instruction writes rd_mem
- branch_taken  in  1  EX resolved a taken branch this cycle
- stall_if, stall_id  out  1  hold PC / IF-ID register
- bubble_ex  out  1  load a NOP into ID/EX
- flush_id  out  1  squash the IF/ID contents
- fwd_1, fwd_2  out  FWD_WIDTH  00 regfile, 01 EX result, 10 MEM result
- md_busy  out  1  multiply/divide unit occupied
- md_done  out  1  one-cycle pulse on final MD cycle

## Operation
- States: RUN, MD_BUSY. Counter md_cnt, width $clog2(MD_LATENCY).
- Forwarding is combinational in every state: fwd_n = 01 if use_rnn & ex_write & rd_ex==rnn & !ex_is_load; else 10 if use_rnn & mem_write & rd_mem==rnn; else 00. A match on an EX load never selects 01; MEM match still applies. Register 0 is an ordinary register and is forwarded like any other.
- Load-use hazard (lu) = ex_write & ex_is_load & ((use_rn1 & rd_ex==rn_1) | (use_rn2 & rd_ex==rn_2)).
- Priority in RUN, highest first:
  1. branch_taken: flush_id=1, bubble_ex=1, stall 0; md_start ignored; stay RUN.
  2. lu: stall_if=stall_id=1, bubble_ex=1; md_start ignored this cycle. Next cycle the load is in MEM, so lu clears and fwd selects 10.
  3. md_start: the MD instruction issues to EX; md_cnt <= MD_LATENCY-2; go to MD_BUSY.
  4. Otherwise all control outputs 0.
- MD_BUSY: md_busy=1, stall_if=stall_id=1, bubble_ex=1 every cycle. Decrement md_cnt. When md_cnt==0, pulse md_done and return to RUN. branch_taken cannot occur, because EX holds the MD op. If asserted anyway, it is ignored.
- Total EX occupancy of an MD op: MD_LATENCY cycles, comprising the issue cycle plus MD_LATENCY-1 busy cycles.

## Timing
- Reset (rst_n low at posedge): state=RUN, md_cnt=0. While rst_n is low, every output is forced to 0 (fwd_1=fwd_2=00).
- Forward selects, lu stall, and flush are same-cycle combinational; state updates at the next edge.
- The load-use stall lasts exactly 1 cycle per hazard. Back-to-back loads feeding each other still give 1 stall each.
- The MD stall starts the cycle after issue. The ID instruction behind the MD op resumes the cycle after md_done.
- Reset asserted mid-MD_BUSY returns the block to RUN at that edge. No md_done is produced.

## Test plan
- EX add writes r3, MEM writes r3, ID reads rn_1=3 -> fwd_1=01. The next cycle, with only MEM matching -> fwd_1=10.
- EX load to r5, ID reads rn_2=5 -> one cycle with stall_if=stall_id=bubble_ex=1. The next cycle has stalls 0 and fwd_2=10.
- md_start with MD_LATENCY=4 -> md_busy high for 3 cycles, md_done high on the 3rd, stalls released the following cycle.
- branch_taken together with md_start and lu -> flush_id=bubble_ex=1, stall 0, and state remains RUN.
- rst_n driven low during the 2nd MD_BUSY cycle -> outputs 0 immediately, RUN after the edge, no md_done.
- use_rn1=0 with rn_1==rd_ex on a load -> no stall, fwd_1=00.
